// File: rtl/conv_out_collector.sv
// Receiving end of the conv pixel stream: keeps the OUT_DIM x OUT_DIM samples whose
// K x K window is complete, then drains them in raster order over valid/ready.
module conv_out_collector #(
  parameter int DIM = 28,
  parameter int K   = 5,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] conv_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          frame_done,
  output logic          busy,
  output logic          overrun
);

  localparam int OUT_DIM = DIM - K + 1;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int RW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [RW-1:0] WIN_START = RW'(K - 1);
  localparam logic [RW-1:0] EDGE      = RW'(DIM - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  typedef enum logic {CAPTURE, DRAIN} state_t;

  state_t        state;
  logic [RW-1:0] row, col;
  logic [PW-1:0] wptr, rptr, rptr_nxt;
  logic [DW-1:0] mem [DEPTH];

  logic beat, in_window, frame_end, xfer, load_first;

  // NOTE: every signal is assigned on every pass through this block, so no latch
  // is inferred; combinational logic uses blocking '=' while state uses '<='.
  always_comb begin
    beat       = (state == CAPTURE) && in_valid;
    in_window  = (row >= WIN_START) && (col >= WIN_START);
    frame_end  = (row == EDGE) && (col == EDGE);
    xfer       = out_valid && out_ready;
    load_first = (state == DRAIN) && !out_valid;
    rptr_nxt   = load_first ? '0 : rptr + PW'(1);
  end

  // NOTE: the result RAM has no reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (beat && in_window) mem[wptr] <= conv_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= CAPTURE;
      row        <= '0;
      col        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == DRAIN && in_valid) overrun <= 1'b1;

      case (state)
        CAPTURE: begin
          if (in_valid) begin
            if (in_window) wptr <= wptr + PW'(1);
            if (frame_end) begin
              state <= DRAIN;
              busy  <= 1'b1;
              row   <= '0;
              col   <= '0;
              wptr  <= '0;
            end else if (col == EDGE) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
          end
        end

        DRAIN: begin
          // The output register is reloaded only when empty or just consumed,
          // which keeps data and last stable across a stall.
          if (load_first || (xfer && !out_last)) begin
            out_valid <= 1'b1;
            out_data  <= mem[rptr_nxt];
            out_last  <= (rptr_nxt == LAST_PTR);
            rptr      <= rptr_nxt;
          end else if (xfer) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            rptr       <= '0;
            state      <= CAPTURE;
          end
        end

        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: default 28/5 instance plus a 4/3 instance,
// checked against a raster model of which samples survive the window crop.
module tb_conv_out_collector;

  localparam int DIM     = 28;
  localparam int K       = 5;
  localparam int OUT_DIM = DIM - K + 1;
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam int NBEATS  = DIM * DIM;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] conv_in;
  logic       out_valid, out_last, frame_done, busy, overrun;
  logic [7:0] out_data;

  logic       s_in_valid, s_out_ready;
  logic [7:0] s_conv_in;
  logic       s_out_valid, s_out_last, s_frame_done, s_busy, s_overrun;
  logic [7:0] s_out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] got [DEPTH];
  logic       got_last [DEPTH];

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } vec_t;

  always #5 clk = ~clk;

  conv_out_collector #(.DIM(DIM), .K(K), .DW(8)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid), .conv_in(conv_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  conv_out_collector #(.DIM(4), .K(3), .DW(8)) dut_small (
    .clk(clk), .reset(rst_n), .in_valid(s_in_valid), .conv_in(s_conv_in),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .frame_done(s_frame_done), .busy(s_busy), .overrun(s_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_val(input int offset, input int idx);
    int r, c;
    r = idx / OUT_DIM + K - 1;
    c = idx % OUT_DIM + K - 1;
    return 8'(r * DIM + c + offset);
  endfunction

  // Feeds beats 0..nbeats-1 starting just after a rising edge; returns just after
  // the edge that sampled the final beat. hold keeps in_valid high afterwards.
  task automatic feed(input int offset, input bit gaps, input int nbeats, input bit hold);
    for (int p = 0; p < nbeats; p++) begin
      if (gaps && p > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      conv_in  = 8'(p + offset);
      @(posedge clk); #1;
    end
    in_valid = hold;
    conv_in  = 8'hEE;
  endtask

  task automatic drain(input int offset, input bit rnd, input bit exp_ovr);
    int   idx = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic [7:0] held_d = '0;
    logic held_l = 1'b0;
    check("busy_first_drain_cycle", busy, 1);
    check("out_valid_early", out_valid, 0);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    check("out_valid_latency", out_valid, 1);
    check("overrun_in_drain", overrun, exp_ovr);
    while (idx < DEPTH && cyc < 5000) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held_d);
        check("stall_last", out_last, held_l);
      end
      if (out_valid && out_ready) begin
        check("data", out_data, exp_val(offset, idx));
        check("last", out_last, (idx == DEPTH - 1));
        got[idx]      = out_data;
        got_last[idx] = out_last;
        idx++;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
      cyc++;
    end
    check("drain_count", idx, DEPTH);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("frame_done_pulse", frame_done, 1);
    check("out_valid_after_last", out_valid, 0);
    check("busy_after_last", busy, 0);
    check("out_last_after_last", out_last, 0);
    @(posedge clk); #1;
    check("frame_done_one_cycle", frame_done, 0);
  endtask

  initial begin
    vec_t spot [6];
    vec_t small_tab [4];
    logic [7:0] s_got [4];
    logic       s_got_last [4];
    int         s_cnt;

    spot[0] = '{idx: 0,   data: 8'h74, last: 1'b0};
    spot[1] = '{idx: 1,   data: 8'h75, last: 1'b0};
    spot[2] = '{idx: 2,   data: 8'h76, last: 1'b0};
    spot[3] = '{idx: 23,  data: 8'h8B, last: 1'b0};
    spot[4] = '{idx: 24,  data: 8'h90, last: 1'b0};
    spot[5] = '{idx: 575, data: 8'h0F, last: 1'b1};
    small_tab[0] = '{idx: 0, data: 8'd10, last: 1'b0};
    small_tab[1] = '{idx: 1, data: 8'd11, last: 1'b0};
    small_tab[2] = '{idx: 2, data: 8'd14, last: 1'b0};
    small_tab[3] = '{idx: 3, data: 8'd15, last: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; conv_in = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_conv_in = '0; s_out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Small 4x4 / 3x3 instance: ramp frame, four results.
    for (int p = 0; p < 16; p++) begin
      s_in_valid = 1'b1;
      s_conv_in  = 8'(p);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    s_cnt = 0;
    for (int c = 0; c < 40 && s_cnt < 4; c++) begin
      @(negedge clk);
      if (s_out_valid) begin
        s_got[s_cnt]      = s_out_data;
        s_got_last[s_cnt] = s_out_last;
        s_cnt++;
      end
    end
    check("small_count", s_cnt, 4);
    for (int i = 0; i < 4 && i < s_cnt; i++) begin
      check("small_data", s_got[small_tab[i].idx], small_tab[i].data);
      check("small_last", s_got_last[small_tab[i].idx], small_tab[i].last);
    end
    repeat (2) @(negedge clk);
    check("small_no_extra", s_out_valid, 0);
    @(posedge clk); #1;

    // Continuous ramp frame, spot values from the table.
    feed(0, 1'b0, NBEATS, 1'b0);
    drain(0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("spot_data", got[spot[i].idx], spot[i].data);
      check("spot_last", got_last[spot[i].idx], spot[i].last);
    end
    check("no_overrun", overrun, 0);

    // Gapped input and random backpressure.
    feed(0, 1'b1, NBEATS, 1'b0);
    drain(0, 1'b1, 1'b0);

    // in_valid held through drain: sticky overrun, next frame restarts at 0.
    feed(0, 1'b0, NBEATS, 1'b1);
    drain(0, 1'b0, 1'b1);
    check("overrun_sticky", overrun, 1);
    feed(0, 1'b0, NBEATS, 1'b0);
    drain(0, 1'b0, 1'b1);
    check("overrun_next_frame", overrun, 1);

    // Reset mid-frame at beat 300.
    feed(0, 1'b0, 300, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    feed(0, 1'b0, NBEATS, 1'b0);
    drain(0, 1'b0, 1'b0);

    // Back-to-back frames with offsets 0 and 50.
    feed(0, 1'b0, NBEATS, 1'b0);
    drain(0, 1'b0, 1'b0);
    feed(50, 1'b0, NBEATS, 1'b0);
    drain(50, 1'b0, 1'b0);
    check("offset_first", got[0], 8'hA6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
